// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
//   Bundles the signals between the UART receiver, the receive FIFO and the
//   host-side consumer. Clock and reset are kept as plain ports on the FIFO.
//
//   Receiver side : in_data, in_valid, in_parity_err, in_frame_err
//   Consumer side : rd_data, rd_parity_err, rd_frame_err, rd_valid, rd_ready
//   Status/control: count, full, overrun, clr_overrun, drop_cnt
//
//   modport slave  : the FIFO itself
//   modport master : the environment (receiver, consumer, status reader)
interface uart_rx_fifo_if #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_BITS-1:0] in_data;
    logic                 in_valid;
    logic                 in_parity_err;
    logic                 in_frame_err;

    logic [DATA_BITS-1:0] rd_data;
    logic                 rd_parity_err;
    logic                 rd_frame_err;
    logic                 rd_valid;
    logic                 rd_ready;

    logic [CW-1:0]        count;
    logic                 full;
    logic                 overrun;
    logic                 clr_overrun;
    logic [7:0]           drop_cnt;

    modport slave (
        input  in_data, in_valid, in_parity_err, in_frame_err,
        input  rd_ready, clr_overrun,
        output rd_data, rd_parity_err, rd_frame_err, rd_valid,
        output count, full, overrun, drop_cnt
    );

    modport master (
        output in_data, in_valid, in_parity_err, in_frame_err,
        output rd_ready, clr_overrun,
        input  rd_data, rd_parity_err, rd_frame_err, rd_valid,
        input  count, full, overrun, drop_cnt
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive buffer between the UART receiver and the host consumer. Each
//   in_valid strobe stores {frame_err, parity_err, data} in a DEPTH-entry
//   queue; the head entry is presented show-ahead on a valid/ready port.
//   The receiver cannot be stalled, so a character arriving while the queue
//   is full (and no read happens that cycle) is lost and sets sticky overrun.
//
//   Ports:
//     clk    : clock
//     reset  : asynchronous, active-high reset
//     bus    : uart_rx_fifo_if.slave (input strobe, read port, status)
//
//   Build option UART_RX_FIFO_DROP_ERR_EN:
//     defined   - characters with a parity or framing error are discarded,
//                 counted in drop_cnt (saturating at 255), never cause
//                 overrun; rd_parity_err / rd_frame_err read as 0.
//     undefined - every character is stored with its flags; drop_cnt = 0.
module uart_rx_fifo #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16
) (
    input  logic          clk,
    input  logic          reset,
    uart_rx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_BITS + 2;

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overrun_q, overrun_d;

    logic          full;
    logic          empty;
    logic          rd_fire;
    logic          in_drop;
    logic          wr_en;
    logic [EW-1:0] head;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign rd_fire = !empty && bus.rd_ready;

`ifdef UART_RX_FIFO_DROP_ERR_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    assign in_drop = bus.in_valid && (bus.in_parity_err || bus.in_frame_err);

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (in_drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.drop_cnt = drop_cnt_q;
`else
    assign in_drop      = 1'b0;
    assign bus.drop_cnt = '0;
`endif

    // A full queue can still take a character when the head leaves in the
    // same cycle; the freed slot is reused immediately.
    assign wr_en = bus.in_valid && !in_drop && (!full || rd_fire);

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        if (wr_en) begin
            mem_d[wr_ptr_q] = {bus.in_frame_err, bus.in_parity_err, bus.in_data};
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        if (wr_en && !rd_fire) begin
            count_d = count_q + CNT_ONE;
        end else if (!wr_en && rd_fire) begin
            count_d = count_q - CNT_ONE;
        end

        // A lost character outranks a clear in the same cycle.
        if (bus.in_valid && !in_drop && full && !rd_fire) begin
            overrun_d = 1'b1;
        end else if (bus.clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage needs no reset: stale contents are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head = mem_q[rd_ptr_q];

    assign bus.rd_data  = head[DATA_BITS-1:0];
    assign bus.rd_valid = !empty;
    assign bus.count    = count_q;
    assign bus.full     = full;
    assign bus.overrun  = overrun_q;

`ifdef UART_RX_FIFO_DROP_ERR_EN
    logic unused_head_flags;
    assign unused_head_flags  = ^head[EW-1:DATA_BITS];
    assign bus.rd_parity_err  = 1'b0;
    assign bus.rd_frame_err   = 1'b0;
`else
    assign bus.rd_parity_err  = head[DATA_BITS];
    assign bus.rd_frame_err   = head[DATA_BITS+1];
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
    localparam int DATA_BITS = 8;
    localparam int DEPTH     = 16;

`ifdef UART_RX_FIFO_DROP_ERR_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    typedef struct packed {
        logic       fe;
        logic       pe;
        logic [7:0] d;
    } ent_t;

    logic clk;
    logic reset;

    uart_rx_fifo_if #(.DATA_BITS(DATA_BITS), .DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(.DATA_BITS(DATA_BITS), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    ent_t q[$];
    bit   m_overrun;
    int   m_drop;

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        chk({tag, ".count"},    32'(bus.count),    32'(q.size()));
        chk({tag, ".full"},     32'(bus.full),     32'(q.size() == DEPTH));
        chk({tag, ".overrun"},  32'(bus.overrun),  32'(m_overrun));
        chk({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(q.size() != 0));
        chk({tag, ".drop_cnt"}, 32'(bus.drop_cnt), 32'(m_drop));
        if (q.size() != 0) begin
            chk({tag, ".rd_data"},  32'(bus.rd_data),       32'(q[0].d));
            chk({tag, ".rd_perr"},  32'(bus.rd_parity_err), 32'(q[0].pe));
            chk({tag, ".rd_ferr"},  32'(bus.rd_frame_err),  32'(q[0].fe));
        end
    endtask

    // Called at posedge+1; drives one cycle, updates the model from the
    // behavioural rules and checks the outputs just after the edge.
    task automatic cycle(input string tag, input logic v, input logic [7:0] d,
                         input logic pe, input logic fe, input logic rr, input logic clr);
        bit fire, drop, lost;
        ent_t e;
        bus.in_valid      = v;
        bus.in_data       = d;
        bus.in_parity_err = pe;
        bus.in_frame_err  = fe;
        bus.rd_ready      = rr;
        bus.clr_overrun   = clr;
        fire = (q.size() != 0) && rr;
        drop = DROP_EN && v && (pe || fe);
        lost = v && !drop && (q.size() == DEPTH) && !fire;
        @(posedge clk);
        #1;
        if (fire) void'(q.pop_front());
        if (v && !drop && !lost) begin
            e.fe = fe; e.pe = pe; e.d = d;
            q.push_back(e);
        end
        if (lost) m_overrun = 1'b1;
        else if (clr) m_overrun = 1'b0;
        if (drop && m_drop < 255) m_drop++;
        bus.in_valid    = 1'b0;
        bus.rd_ready    = 1'b0;
        bus.clr_overrun = 1'b0;
        check_status(tag);
    endtask

    task automatic model_reset();
        q.delete();
        m_overrun = 1'b0;
        m_drop    = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] v8;
        reset             = 1'b1;
        bus.in_valid      = 1'b0;
        bus.in_data       = '0;
        bus.in_parity_err = 1'b0;
        bus.in_frame_err  = 1'b0;
        bus.rd_ready      = 1'b0;
        bus.clr_overrun   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_status("reset");

        // fill and drain
        for (int i = 0; i < 16; i++) begin
            v8 = 8'h41 + 8'(i);
            cycle("fill", 1'b1, v8, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("fill.count16", 32'(bus.count), 32'd16);
        chk("fill.full",    32'(bus.full),  32'd1);
        for (int i = 0; i < 16; i++) begin
            chk("drain.data", 32'(bus.rd_data), 32'h41 + 32'(i));
            cycle("drain", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk("drain.rd_valid_low", 32'(bus.rd_valid), 32'd0);

        // overrun and clear, then simultaneous read/write while full
        for (int i = 0; i < 16; i++) begin
            v8 = 8'h41 + 8'(i);
            cycle("refill", 1'b1, v8, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        cycle("ovr", 1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr.set",   32'(bus.overrun), 32'd1);
        chk("ovr.count", 32'(bus.count),   32'd16);
        cycle("ovr_clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr.cleared", 32'(bus.overrun), 32'd0);
        cycle("simul", 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("simul.count",   32'(bus.count),   32'd16);
        chk("simul.overrun", 32'(bus.overrun), 32'd0);
        for (int i = 0; i < 16; i++) begin
            cycle("simul_drain", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk("simul.empty", 32'(bus.rd_valid), 32'd0);

        // error flags
        cycle("err", 1'b1, 8'h12, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef UART_RX_FIFO_DROP_ERR_EN
        chk("err.count0", 32'(bus.count),    32'd0);
        chk("err.drop1",  32'(bus.drop_cnt), 32'd1);
        for (int i = 0; i < 300; i++) begin
            v8 = 8'($urandom);
            cycle("err_sat", 1'b1, v8, 1'($urandom), 1'b1, 1'b0, 1'b0);
        end
        chk("err.drop_sat", 32'(bus.drop_cnt), 32'd255);
        chk("err.no_ovr",   32'(bus.overrun),  32'd0);
`else
        chk("err.head",  32'(bus.rd_data),      32'h12);
        chk("err.ferr",  32'(bus.rd_frame_err), 32'd1);
        chk("err.drop0", 32'(bus.drop_cnt),     32'd0);
        cycle("err_pop", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

        // pointer wrap with streaming read
        for (int i = 0; i < 100; i++) begin
            v8 = 8'(i);
            cycle("wrap", 1'b1, v8, 1'b0, 1'b0, 1'b1, 1'b0);
            assert (bus.count <= 1) else begin
                mismatched++;
                $error("FAIL wrap.count_le1: observed=%0d expected<=1", bus.count);
            end
            compared++;
        end
        cycle("wrap_end", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

        // randomized traffic: write-heavy then read-heavy phases
        for (int i = 0; i < 800; i++) begin
            logic v, rr, pe, fe, clr;
            v   = (i < 400) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
            rr  = (i < 400) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) < 8);
            pe  = ($urandom_range(0, 9) == 0);
            fe  = ($urandom_range(0, 9) == 0);
            clr = ($urandom_range(0, 19) == 0);
            v8  = 8'($urandom);
            cycle("rand", v, v8, pe, fe, rr, clr);
        end

        // reset mid-operation with count 5 and overrun set
        reset = 1'b1;
        #2;
        model_reset();
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            v8 = 8'(i);
            cycle("pre_rst", 1'b1, v8, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        cycle("pre_rst_ovr", 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            cycle("pre_rst_rd", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk("pre_rst.count5", 32'(bus.count),   32'd5);
        chk("pre_rst.ovr",    32'(bus.overrun), 32'd1);
        reset = 1'b1;
        #2;
        model_reset();
        chk("rst_mid.count",    32'(bus.count),    32'd0);
        chk("rst_mid.full",     32'(bus.full),     32'd0);
        chk("rst_mid.overrun",  32'(bus.overrun),  32'd0);
        chk("rst_mid.rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_mid.drop_cnt", 32'(bus.drop_cnt), 32'd0);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        cycle("post_rst_wr", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst.head", 32'(bus.rd_data), 32'hA5);
        cycle("post_rst_rd", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive buffer between the UART receiver and the host-side consumer. Each one-cycle `in_valid` pulse from the receiver carries one character plus its parity and framing error flags. The block stores that whole entry in a first-in first-out queue and presents it to the consumer over a valid/ready interface. The receiver cannot be stalled, so the block detects and flags overrun itself, and it can optionally discard corrupted characters.

## Interface
- `DATA_BITS`, 8, character width; must match the receiver.
- `DEPTH`, 16, number of entries; power of two, ≥ 2.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_data`  in  DATA_BITS  received character; valid only while `in_valid` = 1.
- `in_valid`  in  1  single-cycle strobe, one per received character.
- `in_parity_err`  in  1  parity error flag for this character.
- `in_frame_err`  in  1  stop-bit error flag for this character.
- `rd_data`  out  DATA_BITS  head entry character.
- `rd_parity_err`  out  1  head entry parity flag.
- `rd_frame_err`  out  1  head entry framing flag.
- `rd_valid`  out  1  head entry present; equal to !empty.
- `rd_ready`  in  1  consumer accepts the head entry when `rd_valid` & `rd_ready`.
- `count`  out  $clog2(DEPTH)+1  number of stored entries, range 0..DEPTH.
- `full`  out  1  `count` == DEPTH.
- `overrun`  out  1  sticky flag: a character was lost because the queue was full.
- `clr_overrun`  in  1  clears `overrun`.
- `drop_cnt`  out  8  saturating count of characters discarded for errors.

## Operation
- **Storage.** Array of DEPTH entries. Each entry is {frame_err, parity_err, data}, DATA_BITS+2 bits wide.
- **Pointers.** Write and read pointers are $clog2(DEPTH) bits wide. They wrap from DEPTH-1 to 0 by natural overflow.
- **Write.** Occurs on a cycle with `in_valid` = 1 when the queue is not full, or when it is full and a read handshake occurs in the same cycle.
- **Read handshake.** `rd_valid` & `rd_ready`. Advances the read pointer. `rd_ready` while empty has no effect.
- **Output path.** `rd_*` outputs are driven combinationally from the entry at the read pointer (show-ahead). They are don't-care while `rd_valid` = 0.
- **Count update:**
  - write only: +1
  - read only: −1
  - write and read together: unchanged
  - neither: unchanged
- **Full, no read.** `in_valid` is dropped: stored data and `count` are unchanged, and `overrun` is set.
- **Overrun priority.** `clr_overrun` and a new overrun in the same cycle leave `overrun` = 1 (set wins).
- **Empty.** A write and `rd_ready` in the same cycle: the entry is written, no read occurs, `rd_valid` rises next cycle.
- **In-flight input.** No buffering outside the array; the input is sampled only on the `in_valid` cycle.
- **Reset.** At any time, including mid-burst: pointers, `count`, `overrun` and `drop_cnt` clear; stored contents are discarded.

## Timing
- **Reset values:** `rd_valid` 0, `count` 0, `full` 0, `overrun` 0, `drop_cnt` 0. `rd_data` and the error outputs are don't-care.
- **Write latency.** `in_valid` sampled at edge N updates `count`/`rd_valid` immediately after edge N. The consumer can complete the handshake in cycle N+1.
- **Read.** A handshake at edge N presents the next entry, or deasserts `rd_valid`, after edge N.
- **Throughput.** One write and one read per cycle sustained.
- **Status outputs.** `full`, `count` and `overrun` are registered or derived from registers only; there is no combinational path from `in_valid` or `rd_ready`.

## Configuration
- **Macro:** `UART_RX_FIFO_DROP_ERR_EN`.
- **Defined.** A character with `in_parity_err` | `in_frame_err` = 1 is never written.
  - `drop_cnt` increments by 1 per discarded character and saturates at 255.
  - Discarded characters never affect `overrun`, even when the queue is full.
  - `rd_parity_err` and `rd_frame_err` are always 0.
- **Undefined.** All characters are stored with their flags; `drop_cnt` is tied to 0.

## Test plan
- **Fill and drain.** After reset, write 0x41..0x50 (16 entries), `rd_ready` = 0 → `count` = 16, `full` = 1, `overrun` = 0. Then hold `rd_ready` = 1 → read 0x41..0x50 in order, `rd_valid` falls after the 16th read.
- **Overrun and clear.** Queue full, `in_valid` with 0x99 and no read → `overrun` = 1, `count` = 16, 0x99 never read. Assert `clr_overrun` → `overrun` = 0.
- **Simultaneous read and write.** Queue full, `in_valid` 0x77 with `rd_ready` = 1 → `count` stays 16, `overrun` = 0. 0x77 is read last after the 15 remaining entries.
- **Error flags / drop.** Write 0x12 with `in_frame_err` = 1.
  - Without the macro: head shows 0x12, `rd_frame_err` = 1.
  - With the macro: `count` = 0, `drop_cnt` = 1. After 300 errored writes, `drop_cnt` = 255.
- **Pointer wrap.** Stream 100 characters 0x00..0x63 with `rd_ready` = 1 → every value is read once, in order, `count` ≤ 1 throughout.
- **Reset mid-operation.** Assert `reset` with `count` = 5 and `overrun` = 1 → all status outputs return to 0 at once. The next write of 0xA5 is the first entry read.
